corr_ctrl: RTL and testbench
============================

Name: corr_ctrl

Overview:
- Sequencing controller for the IF down-conversion/correlation datapath.
- Runs the carrier phase NCO that drives the sin/cos lookup, and paces code chips so the M-code generator advances.
- Integrates the downconverter's per-sample I/Q products over one code epoch, then dumps the sums through a valid/ready handshake to the tracking loop.
- Sits between the IF sample strobe and the loop-filter/discriminator stage.

Parameters:
- PHASE_W, 32: carrier NCO accumulator width; carr_phase output width.
- DATA_W, 32: width of the signed i_in/q_in products from the downconverter.
- ACC_W, 48: signed accumulator and dump width.
- CODE_LEN, 1023: chips per code epoch.
- SAMPLES_PER_CHIP, 4: IF samples per chip. INT_LEN = CODE_LEN*SAMPLES_PER_CHIP.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- start  in  1  pulse; latches carr_fcw and begins a run (honoured only in IDLE).
- stop  in  1  pulse; aborts the run and discards the partial integration.
- carr_fcw  in  PHASE_W  carrier frequency control word.
- sample_valid  in  1  one new IF sample this cycle.
- i_in  in  DATA_W signed  downconverter I product; valid one cycle after sample_valid.
- q_in  in  DATA_W signed  downconverter Q product; same alignment as i_in.
- carr_phase  out  PHASE_W  NCO phase to the sin/cos LUT.
- code_adv  out  1  one-cycle pulse; advance code generator one chip.
- chip_idx  out  clog2(CODE_LEN)  current chip index.
- epoch  out  1  one-cycle pulse when chip_idx wraps CODE_LEN-1 -> 0.
- dump_valid  out  1  dump_i/dump_q hold a completed integration.
- dump_ready  in  1  consumer accepts the dump.
- dump_i  out  ACC_W signed  integrated I.
- dump_q  out  ACC_W signed  integrated Q.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; a dump was overwritten before it was accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = IDLE.
  - All outputs 0; all counters, accumulators, NCO and latched fcw cleared.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. In the same cycle: fcw_q <= carr_fcw, carr_phase <= 0, counters <= 0, overrun <= 0.
  - RUN -> DRAIN on stop. DRAIN -> IDLE after exactly one cycle, so the in-flight product is absorbed and discarded.
  - If start and stop are high in the same cycle in IDLE, stay in IDLE.
  - start while in RUN or DRAIN is ignored.
- NCO: in RUN with sample_valid, carr_phase <= carr_phase + fcw_q, modulo 2^PHASE_W (natural wrap). Frozen in IDLE and DRAIN.
- Chip pacing: in RUN with sample_valid, spc_cnt counts 0..SAMPLES_PER_CHIP-1.
  - When spc_cnt==SAMPLES_PER_CHIP-1: next cycle code_adv=1, spc_cnt <= 0, chip_idx increments.
  - chip_idx wraps CODE_LEN-1 -> 0, and epoch=1 on that same cycle as code_adv.
- Integration:
  - prod_v = sample_valid delayed one cycle, gated by state==RUN at the time of the sample. The downconverter has 1-cycle latency.
  - On prod_v: acc <= acc + sign-extended i_in/q_in, and s_cnt increments.
  - When s_cnt==INT_LEN-1 and prod_v: dump_i/q <= acc + input, dump_valid <= 1, acc <= 0, s_cnt <= 0. Integration is continuous; no sample is lost at the boundary.
- Handshake:
  - dump_valid is held until a cycle with dump_valid && dump_ready; it clears the next cycle unless a new dump lands in that same cycle.
  - If a new dump completes while dump_valid=1 and dump_ready=0: data is overwritten, dump_valid stays 1, overrun <= 1.
  - Accept and new dump in the same cycle: the new data is loaded, dump_valid stays 1, no overrun.
- stop or reset mid-integration: acc and s_cnt cleared, no dump produced. A pending dump stays valid through stop; only reset clears it.
- Arithmetic: two's complement throughout, no saturation. ACC_W must be >= DATA_W + clog2(INT_LEN).

Decomposition:
- Shared package corr_pkg:
  - State enum constants (IDLE/RUN/DRAIN).
  - Defaults for PHASE_W, ACC_W, CODE_LEN, SAMPLES_PER_CHIP.
  - INT_LEN and chip-index width as derived constants.
- One natural sub-module: corr_nco (phase accumulator with enable and clear), reused for a future code NCO.

Test Plan (CODE_LEN=4, SAMPLES_PER_CHIP=2, INT_LEN=8, sample_valid every cycle unless noted):
- Reset: hold reset=0 for 3 cycles with start=1 -> busy=0, dump_valid=0, carr_phase=0, overrun=0.
- NCO: start with carr_fcw=0x40000000 -> carr_phase steps 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (wrap).
- Chip pacing: 8 samples -> code_adv on every 2nd sample, chip_idx 1,2,3,0; epoch once, coincident with chip_idx returning to 0.
- Integrate/dump: i_in=+3, q_in=-2 constant, dump_ready=1 -> dump_i=24, dump_q=-16, one-cycle dump_valid every 8 products. Sample gaps (sample_valid 50%) stretch the period to 16 cycles with the same sums.
- Backpressure: dump_ready=0 across two epochs -> dump_valid stays high, overrun=1, dump_i shows the second epoch's sum. Next start clears overrun.
- Abort: stop after 5 products -> DRAIN for 1 cycle, then IDLE, no dump_valid. Restart with i_in=+1 -> first dump_i=8.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared types and default sizing for the correlation sequencing controller.
package corr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int PHASE_W_DEF  = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int ACC_W_DEF    = 48;
  localparam int CODE_LEN_DEF = 1023;
  localparam int SPC_DEF      = 4;

  // Counter width that never collapses to zero bits for tiny parameter sets.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int INT_LEN_DEF = CODE_LEN_DEF * SPC_DEF;
  localparam int CHIP_W_DEF  = clog2_min1(CODE_LEN_DEF);

endpackage

// File: rtl/corr_nco.sv
// Phase accumulator with clear and enable; wraps naturally at 2^W.
module corr_nco
  import corr_pkg::*;
#(
  parameter int W = PHASE_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] fcw,
  output logic [W-1:0] phase
);

  logic [W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr)     phase_d = '0;
    else if (en) phase_d = phase_q + fcw;
  end

  always_ff @(posedge clk) begin
    if (!reset) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/corr_ctrl.sv
// Correlation sequencer: carrier NCO, chip pacing, epoch integrate-and-dump
// with a valid/ready output and sticky overrun flag.
module corr_ctrl
  import corr_pkg::*;
#(
  parameter int PHASE_W          = PHASE_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int ACC_W            = ACC_W_DEF,
  parameter int CODE_LEN         = CODE_LEN_DEF,
  parameter int SAMPLES_PER_CHIP = SPC_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [PHASE_W-1:0]                    carr_fcw,
  input  logic                                  sample_valid,
  input  logic signed [DATA_W-1:0]              i_in,
  input  logic signed [DATA_W-1:0]              q_in,
  output logic [PHASE_W-1:0]                    carr_phase,
  output logic                                  code_adv,
  output logic [clog2_min1(CODE_LEN)-1:0]       chip_idx,
  output logic                                  epoch,
  output logic                                  dump_valid,
  input  logic                                  dump_ready,
  output logic signed [ACC_W-1:0]               dump_i,
  output logic signed [ACC_W-1:0]               dump_q,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int INT_LEN = CODE_LEN * SAMPLES_PER_CHIP;
  localparam int CHIP_W  = clog2_min1(CODE_LEN);
  localparam int SPC_W   = clog2_min1(SAMPLES_PER_CHIP);
  localparam int SCNT_W  = clog2_min1(INT_LEN);

  state_e                   state_q, state_d;
  logic [PHASE_W-1:0]       fcw_q, fcw_d;
  logic [SPC_W-1:0]         spc_cnt_q, spc_cnt_d;
  logic [CHIP_W-1:0]        chip_idx_q, chip_idx_d;
  logic                     code_adv_q, code_adv_d;
  logic                     epoch_q, epoch_d;
  logic                     prod_v_q, prod_v_d;
  logic [SCNT_W-1:0]        s_cnt_q, s_cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0]  dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic                     dump_valid_q, dump_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     start_go, run_go, adv;
  logic signed [ACC_W-1:0]  sum_i, sum_q;

  assign start_go = (state_q == IDLE) && start && !stop;
  assign run_go   = (state_q == RUN) && !stop;
  assign adv      = run_go && sample_valid;
  assign sum_i    = acc_i_q + {{(ACC_W-DATA_W){i_in[DATA_W-1]}}, i_in};
  assign sum_q    = acc_q_q + {{(ACC_W-DATA_W){q_in[DATA_W-1]}}, q_in};

  always_comb begin
    state_d      = state_q;
    fcw_d        = fcw_q;
    spc_cnt_d    = spc_cnt_q;
    chip_idx_d   = chip_idx_q;
    code_adv_d   = 1'b0;
    epoch_d      = 1'b0;
    prod_v_d     = sample_valid && (state_q == RUN);
    s_cnt_d      = s_cnt_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    dump_i_d     = dump_i_q;
    dump_q_d     = dump_q_q;
    dump_valid_d = dump_valid_q;
    overrun_d    = overrun_q;

    if (dump_valid_q && dump_ready) dump_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d    = RUN;
          fcw_d      = carr_fcw;
          spc_cnt_d  = '0;
          chip_idx_d = '0;
          s_cnt_d    = '0;
          acc_i_d    = '0;
          acc_q_d    = '0;
          overrun_d  = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
          s_cnt_d = '0;
          acc_i_d = '0;
          acc_q_d = '0;
        end
      end
      DRAIN: begin
        // The product of the stop-cycle sample arrives here and is dropped.
        state_d = IDLE;
        s_cnt_d = '0;
        acc_i_d = '0;
        acc_q_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (spc_cnt_q == SPC_W'(SAMPLES_PER_CHIP-1)) begin
        spc_cnt_d  = '0;
        code_adv_d = 1'b1;
        if (chip_idx_q == CHIP_W'(CODE_LEN-1)) begin
          chip_idx_d = '0;
          epoch_d    = 1'b1;
        end else begin
          chip_idx_d = chip_idx_q + CHIP_W'(1);
        end
      end else begin
        spc_cnt_d = spc_cnt_q + SPC_W'(1);
      end
    end

    // ACC_W must cover DATA_W + clog2(INT_LEN) so an epoch sum cannot wrap.
    if (run_go && prod_v_q) begin
      if (s_cnt_q == SCNT_W'(INT_LEN-1)) begin
        if (dump_valid_q && !dump_ready) overrun_d = 1'b1;
        dump_i_d     = sum_i;
        dump_q_d     = sum_q;
        dump_valid_d = 1'b1;
        acc_i_d      = '0;
        acc_q_d      = '0;
        s_cnt_d      = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        s_cnt_d = s_cnt_q + SCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      fcw_q        <= '0;
      spc_cnt_q    <= '0;
      chip_idx_q   <= '0;
      code_adv_q   <= 1'b0;
      epoch_q      <= 1'b0;
      prod_v_q     <= 1'b0;
      s_cnt_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcw_q        <= fcw_d;
      spc_cnt_q    <= spc_cnt_d;
      chip_idx_q   <= chip_idx_d;
      code_adv_q   <= code_adv_d;
      epoch_q      <= epoch_d;
      prod_v_q     <= prod_v_d;
      s_cnt_q      <= s_cnt_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      dump_i_q     <= dump_i_d;
      dump_q_q     <= dump_q_d;
      dump_valid_q <= dump_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  corr_nco #(.W(PHASE_W)) u_carr_nco (
    .clk   (clk),
    .reset (reset),
    .clr   (start_go),
    .en    (adv),
    .fcw   (fcw_q),
    .phase (carr_phase)
  );

  assign code_adv   = code_adv_q;
  assign chip_idx   = chip_idx_q;
  assign epoch      = epoch_q;
  assign dump_valid = dump_valid_q;
  assign dump_i     = dump_i_q;
  assign dump_q     = dump_q_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_corr_ctrl.sv
// Directed + randomized bench for corr_ctrl against a count-based reference model.
module tb_corr_ctrl;

  localparam int CODE_LEN = 4;
  localparam int SPC      = 2;
  localparam int INT_LEN  = CODE_LEN * SPC;

  logic               clk, reset, start, stop, sample_valid, dump_ready;
  logic [31:0]        carr_fcw, carr_phase;
  logic signed [31:0] i_in, q_in;
  logic               code_adv, epoch, dump_valid, busy, overrun;
  logic [1:0]         chip_idx;
  logic signed [47:0] dump_i, dump_q;

  corr_ctrl #(
    .PHASE_W(32), .DATA_W(32), .ACC_W(48),
    .CODE_LEN(CODE_LEN), .SAMPLES_PER_CHIP(SPC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .carr_fcw(carr_fcw),
    .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
    .carr_phase(carr_phase), .code_adv(code_adv), .chip_idx(chip_idx), .epoch(epoch),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_i(dump_i), .dump_q(dump_q),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc_n = 0;

  // Reference model: run state, sample/product counts and running sums.
  int          m_st;               // 0 idle, 1 run, 2 drain
  logic [31:0] m_fcw;
  int unsigned m_ns;               // samples taken since start
  int          m_np;               // products in current epoch
  longint      m_ai, m_aq, m_di, m_dq;
  bit          m_dv, m_ovr, m_adv, m_ep;
  bit          p_v;                // product of last cycle's sample is due now
  int          p_i, p_q;
  bit          cmode;
  int          ci, cq;
  logic [31:0] fcw_in;
  int          dv_cnt;
  logic [47:0] last_di, last_dq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cyc(input bit sv, input bit rdy, input bit st, input bit sp);
    int ni, nq;
    bit was_run, got_dump;
    logic [31:0] ph;
    ni = cmode ? ci : int'($urandom);
    nq = cmode ? cq : int'($urandom);
    start = st; stop = sp; sample_valid = sv; dump_ready = rdy; carr_fcw = fcw_in;
    i_in = p_v ? p_i : $urandom;
    q_in = p_v ? p_q : $urandom;
    @(posedge clk);
    cyc_n++;
    was_run = (m_st == 1);
    got_dump = 1'b0;
    m_adv = 1'b0; m_ep = 1'b0;
    case (m_st)
      0: if (st && !sp) begin
           m_st = 1; m_fcw = fcw_in; m_ns = 0; m_np = 0; m_ai = 0; m_aq = 0; m_ovr = 1'b0;
         end
      1: if (sp) begin
           m_st = 2; m_np = 0; m_ai = 0; m_aq = 0;
         end else begin
           if (p_v) begin
             m_ai += longint'(p_i); m_aq += longint'(p_q); m_np++;
             if (m_np == INT_LEN) begin
               got_dump = 1'b1;
               if (m_dv && !rdy) m_ovr = 1'b1;
               m_di = m_ai; m_dq = m_aq; m_ai = 0; m_aq = 0; m_np = 0;
             end
           end
           if (sv) begin
             m_ns++;
             if (m_ns % SPC == 0) begin
               m_adv = 1'b1;
               m_ep  = ((m_ns / SPC) % CODE_LEN) == 0;
             end
           end
         end
      default: m_st = 0;
    endcase
    if (got_dump) m_dv = 1'b1;
    else if (m_dv && rdy) m_dv = 1'b0;
    p_v = sv && was_run; p_i = ni; p_q = nq;
    #1;
    ph = m_fcw * m_ns;
    chk("busy", busy, m_st != 0);
    chk("carr_phase", carr_phase, ph);
    chk("chip_idx", chip_idx, (m_ns / SPC) % CODE_LEN);
    chk("code_adv", code_adv, m_adv);
    chk("epoch", epoch, m_ep);
    chk("dump_valid", dump_valid, m_dv);
    chk("overrun", overrun, m_ovr);
    if (m_dv) begin
      last_di = m_di[47:0];
      last_dq = m_dq[47:0];
      chk("dump_i", dump_i[47:0], last_di);
      chk("dump_q", dump_q[47:0], last_dq);
    end
    if (dump_valid) dv_cnt++;
  endtask

  task automatic halt_run();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; stop = 1'b0; sample_valid = 1'b1; dump_ready = 1'b0;
    carr_fcw = 32'h1234_5678; i_in = 32'sd5; q_in = 32'sd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_carr_phase", carr_phase, 32'h0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b1; start = 1'b0;
    m_st = 0; m_fcw = '0; m_ns = 0; m_np = 0; m_ai = 0; m_aq = 0; m_di = 0; m_dq = 0;
    m_dv = 0; m_ovr = 0; p_v = 0; p_i = 0; p_q = 0;

    // NCO wrap, chip pacing and constant-product dumps
    cmode = 1'b1; ci = 3; cq = -2; fcw_in = 32'h4000_0000;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    dv_cnt = 0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("nco_wrap", carr_phase, 32'h0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("const_dumps", dv_cnt, 2);
    chk("const_di", last_di, 48'd24);
    chk("const_dq", last_dq, 48'hFFFF_FFFF_FFF0);
    halt_run();

    // 50% sample gaps: same sums, period 16
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    dv_cnt = 0;
    for (int k = 1; k <= 34; k++) cyc(k[0], 1'b1, 1'b0, 1'b0);
    chk("gap_dumps", dv_cnt, 2);
    chk("gap_di", last_di, 48'd24);
    chk("gap_dq", last_dq, 48'hFFFF_FFFF_FFF0);
    halt_run();

    // Backpressure across two epochs with random products
    cmode = 1'b0; fcw_in = $urandom;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_overrun", overrun, 1'b1);
    chk("bp_valid", dump_valid, 1'b1);
    chk("bp_di_second", dump_i[47:0], m_di[47:0]);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_pending_after_stop", dump_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("bp_restart_overrun", overrun, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    halt_run();

    // Abort after 5 products, then restart with +1
    cmode = 1'b1; ci = 7; cq = 7;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    dv_cnt = 0;
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort_drain", busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_dump", dv_cnt, 0);
    ci = 1; cq = 1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_restart_dumps", dv_cnt, 1);
    chk("abort_restart_di", last_di, 48'd8);

    // Randomized traffic
    cmode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bit r_st, r_sp;
      r_st = ($urandom_range(0, 19) == 0);
      r_sp = ($urandom_range(0, 59) == 0);
      if (r_st) fcw_in = $urandom;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, r_st, r_sp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
